// File: rtl/sale_ctrl.sv
// -----------------------------------------------------------------------------
// sale_ctrl
//   Top-level sequencer of the ticket vending machine. It latches the
//   passenger's ticket selection and prices it, then accumulates inserted coins.
//   Once the amount paid covers the price, it loads the ticket dispenser and
//   runs it. Finally it reports the change.
//   If no coin arrives for TIMEOUT_CYC cycles while waiting for payment, the
//   transaction is aborted and everything paid so far is refunded.
//
// Optional feature (compile-time macro):
//   SALE_CANCEL_EN - when defined, cancel=1 during payment aborts the sale and
//                    refunds the coins paid. When undefined, the cancel port
//                    exists but has no effect.
//
// Ports:
//   clk           in   system clock, all logic on posedge
//   rst           in   synchronous active-high reset
//   sel_valid     in   selection strobe (sampled in IDLE only)
//   sel_type[1:0] in   ticket type 0..3
//   sel_count[1:0]in   ticket count 1..3 (0 = invalid, ignored)
//   coin_valid    in   one coin accepted this cycle
//   coin_value[1:0]in  00=1, 01=5, 10=10 yuan, 11=invalid (ignored)
//   cancel        in   abort request (only with SALE_CANCEL_EN)
//   disp_en       out  dispenser enable: 1 = load/hold, 0 = run
//   disp_type[2:0]out  ticket type to dispenser
//   disp_count[2:0]out ticket count to dispenser
//   busy          out  high in every state except IDLE
//   price[6:0]    out  latched total price
//   paid[6:0]     out  coins accumulated in this transaction
//   change_valid  out  one-cycle pulse, change_amt valid
//   change_amt[6:0]out change or refund amount
//   done          out  one-cycle pulse, tickets were dispensed
// -----------------------------------------------------------------------------
module sale_ctrl #(
  parameter int PRICE0      = 2,
  parameter int PRICE1      = 3,
  parameter int PRICE2      = 4,
  parameter int PRICE3      = 5,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel_valid,
  input  logic [1:0] sel_type,
  input  logic [1:0] sel_count,
  input  logic       coin_valid,
  input  logic [1:0] coin_value,
  input  logic       cancel,
  output logic       disp_en,
  output logic [2:0] disp_type,
  output logic [2:0] disp_count,
  output logic       busy,
  output logic [6:0] price,
  output logic [6:0] paid,
  output logic       change_valid,
  output logic [6:0] change_amt,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAY,
    ST_LOAD,
    ST_RUN,
    ST_CHANGE
  } state_t;

  // The idle counter only has to reach TIMEOUT_CYC-1.
  localparam int              TMO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [1:0]       sel_type_q, sel_type_d;
  logic [1:0]       sel_count_q, sel_count_d;
  logic [2:0]       disp_type_q, disp_type_d;
  logic [2:0]       disp_count_q, disp_count_d;
  logic [6:0]       price_q, price_d;
  logic [6:0]       paid_q, paid_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [2:0]       run_q, run_d;
  logic             refund_q, refund_d;

  logic       coin_ok;
  logic [6:0] coin_amt;
  logic [6:0] unit_price;
  logic [2:0] run_last;
  logic       cancel_req;

`ifdef SALE_CANCEL_EN
  assign cancel_req = cancel;
`else
  // Cancel has no effect in this build. It is masked to zero.
  assign cancel_req = cancel & 1'b0;
`endif

  // Decode the coin denomination. Code 11 is treated as "no coin".
  always_comb begin
    coin_ok  = coin_valid && (coin_value != 2'b11);
    coin_amt = 7'd0;
    case (coin_value)
      2'b00:   coin_amt = 7'd1;
      2'b01:   coin_amt = 7'd5;
      2'b10:   coin_amt = 7'd10;
      default: coin_amt = 7'd0;
    endcase
  end

  // Look up the unit price of the type currently on the selection inputs.
  always_comb begin
    unit_price = 7'(PRICE0);
    case (sel_type)
      2'd0:    unit_price = 7'(PRICE0);
      2'd1:    unit_price = 7'(PRICE1);
      2'd2:    unit_price = 7'(PRICE2);
      default: unit_price = 7'(PRICE3);
    endcase
  end

  // The dispenser runs for two cycles per ticket: one output toggle per clock.
  assign run_last = {disp_count_q[1:0], 1'b0} - 3'd1;

  // Next-state and datapath logic for the whole sale sequence.
  always_comb begin
    state_d      = state_q;
    sel_type_d   = sel_type_q;
    sel_count_d  = sel_count_q;
    disp_type_d  = disp_type_q;
    disp_count_d = disp_count_q;
    price_d      = price_q;
    paid_d       = paid_q;
    tmo_d        = tmo_q;
    run_d        = run_q;
    refund_d     = refund_q;

    case (state_q)
      ST_IDLE: begin
        if (sel_valid && (sel_count != 2'd0)) begin
          sel_type_d  = sel_type;
          sel_count_d = sel_count;
          price_d     = unit_price * {5'd0, sel_count};
          paid_d      = 7'd0;
          tmo_d       = '0;
          refund_d    = 1'b0;
          state_d     = ST_PAY;
        end
      end

      ST_PAY: begin
        // Coins always add while in PAY. This includes the cycle in which
        // the registered total is found to cover the price.
        if (coin_ok) begin
          paid_d = paid_q + coin_amt;
          tmo_d  = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end

        if (cancel_req) begin
          refund_d = 1'b1;
          state_d  = ST_CHANGE;
        end else if (paid_q >= price_q) begin
          disp_type_d  = {1'b0, sel_type_q};
          disp_count_d = {1'b0, sel_count_q};
          run_d        = 3'd0;
          state_d      = ST_LOAD;
        end else if (!coin_ok && (tmo_q == TMO_LAST)) begin
          refund_d = 1'b1;
          state_d  = ST_CHANGE;
        end
      end

      ST_LOAD: begin
        run_d   = 3'd0;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (run_q == run_last) begin
          refund_d = 1'b0;
          state_d  = ST_CHANGE;
        end else begin
          run_d = run_q + 3'd1;
        end
      end

      ST_CHANGE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset discards any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_type_q   <= 2'd0;
      sel_count_q  <= 2'd0;
      disp_type_q  <= 3'd0;
      disp_count_q <= 3'd0;
      price_q      <= 7'd0;
      paid_q       <= 7'd0;
      tmo_q        <= '0;
      run_q        <= 3'd0;
      refund_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_type_q   <= sel_type_d;
      sel_count_q  <= sel_count_d;
      disp_type_q  <= disp_type_d;
      disp_count_q <= disp_count_d;
      price_q      <= price_d;
      paid_q       <= paid_d;
      tmo_q        <= tmo_d;
      run_q        <= run_d;
      refund_q     <= refund_d;
    end
  end

  // Outputs are decoded from the registered state. A refund returns
  // everything paid. A completed sale returns the overpayment.
  always_comb begin
    disp_en      = (state_q != ST_RUN);
    busy         = (state_q != ST_IDLE);
    change_valid = (state_q == ST_CHANGE);
    done         = (state_q == ST_CHANGE) && !refund_q;
    change_amt   = 7'd0;
    if (state_q == ST_CHANGE) begin
      change_amt = refund_q ? paid_q : (paid_q - price_q);
    end
  end

  assign disp_type  = disp_type_q;
  assign disp_count = disp_count_q;
  assign price      = price_q;
  assign paid       = paid_q;

endmodule

// File: tb/tb_sale_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sale_ctrl
//   Scoreboard bench for sale_ctrl. The stimulus side works out each sale from
//   the vending rules. The rules are: price = unit * count, and coins add up
//   until the price is covered. One further coin on the next cycle still
//   counts, and TIMEOUT idle cycles cause a refund.
//   The stimulus side pushes the expected outcome into a queue. A monitor pops
//   that queue on every change pulse and compares.
// -----------------------------------------------------------------------------
module tb_sale_ctrl;

  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel_valid;
  logic [1:0] sel_type;
  logic [1:0] sel_count;
  logic       coin_valid;
  logic [1:0] coin_value;
  logic       cancel;
  logic       disp_en;
  logic [2:0] disp_type;
  logic [2:0] disp_count;
  logic       busy;
  logic [6:0] price;
  logic [6:0] paid;
  logic       change_valid;
  logic [6:0] change_amt;
  logic       done;

  sale_ctrl #(
    .PRICE0(2), .PRICE1(3), .PRICE2(4), .PRICE3(5), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .sel_valid(sel_valid), .sel_type(sel_type), .sel_count(sel_count),
    .coin_valid(coin_valid), .coin_value(coin_value), .cancel(cancel),
    .disp_en(disp_en), .disp_type(disp_type), .disp_count(disp_count),
    .busy(busy), .price(price), .paid(paid),
    .change_valid(change_valid), .change_amt(change_amt), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int amt;
    int done;
    int run_len;
    int cnt;
    int typ;
  } exp_t;

  exp_t exp_q[$];
  int   plan[$];
  int   unit_price[4] = '{2, 3, 4, 5};
  int   checks = 0;
  int   errors = 0;
  int   last_price = 0;
  int   last_paid = 0;
  int   run_len = 0;
  int   seen_type = 0;
  int   seen_count = 0;
  exp_t mon_e;

  // Counts one comparison and reports it if the values differ.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int coin_yuan(input int code);
    case (code)
      0:       return 1;
      1:       return 5;
      2:       return 10;
      default: return 0;
    endcase
  endfunction

  // Drives one selection followed by the coin plan. A plan entry of -1 means
  // no coin. Entry 3 means an invalid coin. While payment is still open, the
  // selection and cancel lines are driven with noise up to noise_until.
  task automatic drive_plan(input int t, input int c, input int noise_until);
    int exp_price;
    exp_price = unit_price[t] * c;
    @(posedge clk); #1;
    sel_valid  = 1'b1;
    sel_type   = 2'(t);
    sel_count  = 2'(c);
    coin_valid = 1'b0;
    for (int i = 0; i < plan.size(); i++) begin
      @(posedge clk); #1;
      sel_valid  = (i <= noise_until) ? 1'($urandom_range(0, 1)) : 1'b0;
      sel_type   = 2'($urandom_range(0, 3));
      sel_count  = 2'($urandom_range(1, 3));
      cancel     = 1'($urandom_range(0, 1));
      coin_valid = (plan[i] >= 0);
      coin_value = (plan[i] >= 0) ? 2'(plan[i]) : 2'($urandom_range(0, 3));
      if (i == 0) begin
        @(negedge clk);
        checkOutput("price latched", int'(price), exp_price);
        checkOutput("paid cleared", int'(paid), 0);
        checkOutput("busy in PAY", int'(busy), 1);
      end
    end
    @(posedge clk); #1;
    sel_valid  = 1'b0;
    coin_valid = 1'b0;
    cancel     = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 300);
    if (busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle wait: busy still %0d after %0d cycles, required 0", busy, n);
    end
  endtask

  // Models one sale from the vending rules, queues the expected result,
  // and then drives the sale.
  task automatic applyStimulus(input int t, input int c);
    int   p;
    int   pd;
    int   idle;
    int   reach;
    int   v;
    bit   refund;
    bit   stop;
    exp_t e;
    p = unit_price[t] * c;
    pd = 0; idle = 0; reach = -1; refund = 0; stop = 0;
    for (int i = 0; i < plan.size() && !stop; i++) begin
      v = (plan[i] >= 0) ? coin_yuan(plan[i]) : 0;
      if (reach >= 0) begin
        pd += v;
        stop = 1;
      end else begin
        if (v > 0) begin
          pd += v;
          idle = 0;
        end else begin
          idle++;
          if (idle == TMO) begin
            refund = 1;
            stop = 1;
          end
        end
        if (!refund && pd >= p) reach = i;
      end
    end
    if (reach < 0) refund = 1;
    e.amt     = refund ? pd : pd - p;
    e.done    = refund ? 0 : 1;
    e.run_len = refund ? 0 : 2 * c;
    e.cnt     = c;
    e.typ     = t;
    exp_q.push_back(e);
    last_price = p;
    last_paid  = pd;
    drive_plan(t, c, reach);
    wait_idle();
  endtask

  function automatic void build_random_plan(input int p);
    int sum;
    int code;
    plan.delete();
    sum = 0;
    while (sum < p) begin
      repeat ($urandom_range(0, 2)) plan.push_back(($urandom_range(0, 1) != 0) ? -1 : 3);
      code = $urandom_range(0, 2);
      plan.push_back(code);
      sum += coin_yuan(code);
    end
    if ($urandom_range(0, 1) != 0) plan.push_back($urandom_range(0, 2));
    plan.push_back(-1);
    plan.push_back($urandom_range(0, 2));
  endfunction

  // Monitor: on each change pulse, pop the next expected outcome and compare.
  // It also measures how long the dispenser was held in run.
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
    end else begin
      if (!disp_en) begin
        run_len++;
        seen_type  = int'(disp_type);
        seen_count = int'(disp_count);
      end
      if (done && !change_valid) begin
        checks++;
        errors++;
        $display("[TB] FAIL done outside change: done=%0d change_valid=%0d, required 0", done, change_valid);
      end
      if (change_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected change pulse: amt=%0d done=%0d, required none", change_amt, done);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("change_amt", int'(change_amt), mon_e.amt);
          checkOutput("done", int'(done), mon_e.done);
          checkOutput("run cycles", run_len, mon_e.run_len);
          if (mon_e.done != 0) begin
            checkOutput("disp_count", seen_count, mon_e.cnt);
            checkOutput("disp_type", seen_type, mon_e.typ);
          end
        end
        run_len = 0;
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; sel_valid = 1'b0; sel_type = 2'd0; sel_count = 2'd0;
    coin_valid = 1'b0; coin_value = 2'd0; cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset disp_en", int'(disp_en), 1);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset price", int'(price), 0);
    checkOutput("reset paid", int'(paid), 0);
    checkOutput("reset change_valid", int'(change_valid), 0);
    checkOutput("reset change_amt", int'(change_amt), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset disp_count", int'(disp_count), 0);
    checkOutput("reset disp_type", int'(disp_type), 0);

    // Directed sales: overpay, exact pay, timeout refund, a gap just short
    // of the timeout, a coin in the cycle after the price is reached,
    // and invalid coins.
    plan = '{1, 1};         applyStimulus(1, 2);
    plan = '{2, 1};         applyStimulus(3, 3);
    plan = '{0};            applyStimulus(0, 1);
    plan.delete();
    plan.push_back(2);
    repeat (TMO - 1) plan.push_back(-1);
    plan.push_back(1);      applyStimulus(3, 3);
    plan = '{1, 2};         applyStimulus(0, 1);
    plan = '{1, -1, 2};     applyStimulus(0, 1);
    plan = '{3, 3, 0, 0};   applyStimulus(0, 1);

    // Zero-count selection and coins while idle must change nothing.
    @(posedge clk); #1;
    sel_valid = 1'b1; sel_count = 2'd0; sel_type = 2'd2;
    coin_valid = 1'b1; coin_value = 2'd1;
    repeat (3) @(posedge clk);
    #1 sel_valid = 1'b0; coin_valid = 1'b0;
    @(negedge clk);
    checkOutput("idle ignore busy", int'(busy), 0);
    checkOutput("idle ignore price", int'(price), last_price);
    checkOutput("idle ignore paid", int'(paid), last_paid);

    // A reset while the dispenser runs abandons the sale without a change pulse.
    plan = '{1, 1};
    drive_plan(1, 2, 1);
    n = 0;
    while (disp_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached RUN before reset", int'(disp_en), 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst in RUN busy", int'(busy), 0);
    checkOutput("rst in RUN disp_en", int'(disp_en), 1);
    checkOutput("rst in RUN paid", int'(paid), 0);
    checkOutput("rst in RUN change_valid", int'(change_valid), 0);
    repeat (10) @(negedge clk);
    last_price = 0;
    last_paid  = 0;

    // Random sales.
    for (int k = 0; k < 40; k++) begin
      int t;
      int c;
      t = $urandom_range(0, 3);
      c = $urandom_range(1, 3);
      build_random_plan(unit_price[t] * c);
      applyStimulus(t, c);
    end

    repeat (5) @(negedge clk);
    checkOutput("pending expectations", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
